// File: rtl/load_store_unit.sv
// RV32I load/store unit: one memory access per start, with ack timeout and lane steering.
// Optional build macro LSU_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] imm,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Counter only needs to reach TIMEOUT_CYCLES-1: the last waiting cycle triggers the abort.
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    addr_q, wdata_q;
    logic [3:0]     we_q;
    logic           store_q;
    logic [2:0]     f3_q;
    logic [1:0]     lo_q;

    logic [31:0]    ea;
    logic           legal;
    logic           misaligned;
    logic           accept;
    logic [3:0]     we_new;
    logic [31:0]    wdata_new;
    logic [7:0]     lane_b;
    logic [15:0]    lane_h;
    logic [31:0]    load_val;

    assign ea = rs1 + imm;

    always_comb begin
        legal = 1'b0;
        if (is_store) begin
            legal = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2);
        end else begin
            legal = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
                    (funct3 == 3'd4) || (funct3 == 3'd5);
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = ((funct3[1:0] == 2'b01) && ea[0]) ||
                        ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign accept = (state_q == IDLE) && start && legal && !misaligned;

    always_comb begin
        we_new    = '0;
        wdata_new = rs2;
        case (funct3[1:0])
            2'b00: begin
                we_new    = 4'b0001 << ea[1:0];
                wdata_new = {4{rs2[7:0]}};
            end
            2'b01: begin
                we_new    = ea[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{rs2[15:0]}};
            end
            default: begin
                we_new    = 4'b1111;
                wdata_new = rs2;
            end
        endcase
        if (!is_store) begin
            we_new = '0;
        end
    end

    always_comb begin
        lane_b = dmem_rdata[7:0];
        case (lo_q)
            2'd0: lane_b = dmem_rdata[7:0];
            2'd1: lane_b = dmem_rdata[15:8];
            2'd2: lane_b = dmem_rdata[23:16];
            2'd3: lane_b = dmem_rdata[31:24];
            default: lane_b = dmem_rdata[7:0];
        endcase
        lane_h = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'd0:    load_val = {{24{lane_b[7]}}, lane_b};
            3'd1:    load_val = {{16{lane_h[15]}}, lane_h};
            3'd4:    load_val = {24'd0, lane_b};
            3'd5:    load_val = {16'd0, lane_h};
            default: load_val = dmem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Access context is captured only for accepted requests, keeping the memory bus quiet otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            store_q <= 1'b0;
            f3_q    <= '0;
            lo_q    <= '0;
        end else if (accept) begin
            addr_q  <= {ea[31:2], 2'b00};
            wdata_q <= wdata_new;
            we_q    <= we_new;
            store_q <= is_store;
            f3_q    <= funct3;
            lo_q    <= ea[1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (start) begin
                    if (!legal || misaligned) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (!store_q) begin
                        rdata_d = load_val;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == RESP);
        err        = (state_q == RESP) && err_q;
        dmem_req   = (state_q == ACCESS);
        dmem_we    = (state_q == ACCESS) ? we_q : '0;
        dmem_addr  = addr_q;
        dmem_wdata = wdata_q;
        rdata      = rdata_q;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum number of cycles dmem_req waits for dmem_ack before aborting.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  issue strobe from decode; sampled only in IDLE.
REQ-005 SHALL have port is_store  input  1  1 = store (SB/SH/SW), 0 = load.
REQ-006 SHALL have port funct3  input  3  RV32I width/sign code: instr[14:12].
REQ-007 SHALL have port rs1  input  32  base register value.
REQ-008 SHALL have port imm  input  32  sign-extended offset from the immediate generator.
REQ-009 SHALL have port rs2  input  32  store data.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  valid with done; 1 = aborted access.
REQ-013 SHALL have port rdata  output  32  extended load result.
REQ-014 SHALL have port dmem_req  output  1  memory request, held until ack or timeout.
REQ-015 SHALL have port dmem_addr  output  32  word address {ea[31:2],2'b00}.
REQ-016 SHALL have port dmem_we  output  4  byte write enables; 0000 for loads.
REQ-017 SHALL have port dmem_wdata  output  32  lane-replicated store data.
REQ-018 SHALL have port dmem_rdata  input  32  memory read word, valid with dmem_ack.
REQ-019 SHALL have port dmem_ack  input  1  memory completion; ignored unless dmem_req is high.

Function
REQ-020 SHALL use FSM states IDLE, ACCESS, RESP.
- IDLE -> ACCESS on start with legal funct3.
- IDLE -> RESP with err=1 on start with illegal funct3.
REQ-021 SHALL latch on start: ea = rs1+imm, modulo 2^32, carry dropped; is_store; funct3; rs2.
REQ-022 SHALL treat funct3 as legal only for: loads 0,1,2,4,5; stores 0,1,2.
REQ-023 SHALL hold dmem_req=1 and dmem_addr, dmem_we, dmem_wdata stable in ACCESS.
- Start in cycle N gives dmem_req=1 in cycle N+1.
REQ-024 SHALL move ACCESS -> RESP in the cycle after dmem_ack=1; a load captures dmem_rdata in that ack cycle.
- An ack in the first ACCESS cycle is legal, giving done two cycles after start.
REQ-025 SHALL count ACCESS cycles; on reaching TIMEOUT_CYCLES without ack, SHALL drop dmem_req and go to RESP with err=1, rdata unchanged.
REQ-026 SHALL in RESP assert done=1 for exactly one cycle, then return to IDLE; done and err are 0 otherwise.
REQ-027 SHALL ignore start while busy=1, with no latch and no queueing.
REQ-028 SHALL generate store lanes as follows:
- SB: we=0001<<ea[1:0], wdata={4{rs2[7:0]}}.
- SH: we=0011<<{ea[1],0}, wdata={2{rs2[15:0]}}.
- SW: we=1111, wdata=rs2.
REQ-029 SHALL extract loads from the byte lane at ea[1:0] and halfword lane at ea[1]:
- LB and LH: sign-extend.
- LBU and LHU: zero-extend.
- LW: whole word.
REQ-030 SHALL leave rdata unchanged on stores and on any err completion.
REQ-031 SHALL keep dmem_req=0 and dmem_we=0000 in IDLE and RESP.

Reset
REQ-032 SHALL on reset=1 at a clock edge force IDLE and set busy, done, err, and dmem_req to 0.
REQ-033 SHALL on reset also set rdata, dmem_addr, dmem_wdata, and the timeout counter to 0, and dmem_we to 0000.
REQ-034 SHALL abort an access on reset mid-ACCESS: dmem_req drops at that edge, no done is produced, and an ack in the following cycle is ignored.

Configuration
REQ-035 SHALL provide macro LSU_MISALIGN_CHECK_EN.
- When defined: LH/LHU/SH with ea[0]=1, and LW/SW with ea[1:0]!=00, go IDLE -> RESP with err=1 and no memory request.
- When undefined: misaligned low bits are ignored (halfword uses ea[1], word ignores ea[1:0]), the access is performed, and err reports only illegal funct3 or timeout.

Verification
REQ-036 SHALL cover: SW with rs1=0x1000, imm=0x4, rs2=0xDEADBEEF, ack on first ACCESS cycle -> dmem_addr=0x1004, we=1111, wdata=0xDEADBEEF, done two cycles after start, err=0.
REQ-037 SHALL cover: LB with ea=0x2003, dmem_rdata=0x80112233 -> rdata=0xFFFFFF80; the same access with LBU -> rdata=0x00000080.
REQ-038 SHALL cover: SH with rs1=0x10, imm=0xFFFFFFF2 (-14), rs2=0x0000ABCD -> ea=0x2, dmem_addr=0x0, we=1100, wdata=0xABCDABCD.
REQ-039 SHALL cover: TIMEOUT_CYCLES=4 with ack held low -> dmem_req high for exactly 4 cycles, then done=1, err=1, rdata unchanged.
REQ-040 SHALL cover: LW with ea=0x1002 -> with LSU_MISALIGN_CHECK_EN, done=1 and err=1 with dmem_req never asserted; without it, dmem_addr=0x1000 and a normal load.
REQ-041 SHALL cover: reset asserted in the second ACCESS cycle, then an ack the next cycle -> dmem_req=0 after the reset edge, no done pulse, and a new start is accepted afterwards.
